// File: rtl/pipe_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_generator
// Purpose  : Scrolls two pipe obstacles, respawns them with LFSR gap heights
//            and keeps a saturating 3-digit BCD score of pipes passed.
// Revision : 1.0
// ============================================================================
module pipe_generator #(
    parameter int        SCREEN_W  = 640,
    parameter int        SPEED     = 1,
    parameter int        BIRD_X    = 100,
    parameter int        GAP_Y_MIN = 100,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic        game_clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        enable,
    output logic [10:0] pipe1_x,
    output logic [10:0] pipe1_y,
    output logic [10:0] pipe2_x,
    output logic [10:0] pipe2_y,
    output logic        score_pulse,
    output logic [11:0] score_bcd
);

    localparam logic [10:0] c_p1_x_rst = 11'(SCREEN_W / 2 - 1);
    localparam logic [10:0] c_p2_x_rst = 11'(SCREEN_W - 1);
    localparam logic [10:0] c_p1_y_rst = 11'd250;
    localparam logic [10:0] c_p2_y_rst = 11'd200;
    localparam logic [10:0] c_respawn  = 11'(SCREEN_W - 1);
    localparam logic [10:0] c_speed    = 11'(SPEED);
    localparam logic [10:0] c_bird     = 11'(BIRD_X);
    localparam logic [10:0] c_gap_min  = 11'(GAP_Y_MIN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [10:0] x1_q, x1_d, y1_q, y1_d;
    logic [10:0] x2_q, x2_d, y2_q, y2_d;
    logic        pulse_q, pulse_d;
    logic [11:0] score_q, score_d;

    logic        w_move;
    logic        w_wrap1, w_wrap2, w_cross1, w_cross2;
    logic [10:0] w_x1_mv, w_x2_mv;

    // Saturating BCD increment with per-digit carry.
    function automatic logic [11:0] bcd_inc(input logic [11:0] s);
        logic [3:0] d2, d1, d0;
        {d2, d1, d0} = s;
        if (s == 12'h999) begin
            return s;
        end
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                d2 = d2 + 4'd1;
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

    assign w_move   = enable && (state_q != HALT);
    assign w_wrap1  = x1_q < c_speed;
    assign w_wrap2  = x2_q < c_speed;
    assign w_x1_mv  = w_wrap1 ? c_respawn : x1_q - c_speed;
    assign w_x2_mv  = w_wrap2 ? c_respawn : x2_q - c_speed;
    assign w_cross1 = !w_wrap1 && (x1_q >= c_bird) && (w_x1_mv < c_bird);
    assign w_cross2 = !w_wrap2 && (x2_q >= c_bird) && (w_x2_mv < c_bird);

    always_comb begin
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        state_d = state_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        x2_d    = x2_q;
        y2_d    = y2_q;
        score_d = score_q;
        pulse_d = 1'b0;

        if (restart) begin
            state_d = IDLE;
            x1_d    = c_p1_x_rst;
            y1_d    = c_p1_y_rst;
            x2_d    = c_p2_x_rst;
            y2_d    = c_p2_y_rst;
            score_d = 12'h000;
        end else begin
            case (state_q)
                IDLE:    if (enable)  state_d = RUN;
                RUN:     if (!enable) state_d = HALT;
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase

            // Spawn heights use the pre-step LFSR; pipe 2 sees it nibble-swapped.
            if (w_move) begin
                x1_d = w_x1_mv;
                x2_d = w_x2_mv;
                if (w_wrap1) y1_d = c_gap_min + {3'b000, lfsr_q};
                if (w_wrap2) y2_d = c_gap_min + {3'b000, lfsr_q[3:0], lfsr_q[7:4]};
                if (w_cross1 || w_cross2) begin
                    pulse_d = 1'b1;
                    score_d = bcd_inc(score_q);
                end
            end
        end
    end

    always_ff @(posedge game_clk) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            x1_q    <= c_p1_x_rst;
            y1_q    <= c_p1_y_rst;
            x2_q    <= c_p2_x_rst;
            y2_q    <= c_p2_y_rst;
            pulse_q <= 1'b0;
            score_q <= 12'h000;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            x2_q    <= x2_d;
            y2_q    <= y2_d;
            pulse_q <= pulse_d;
            score_q <= score_d;
        end
    end

    assign pipe1_x     = x1_q;
    assign pipe1_y     = y1_q;
    assign pipe2_x     = x2_q;
    assign pipe2_y     = y2_q;
    assign score_pulse = pulse_q;
    assign score_bcd   = score_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipe_generator
// Purpose  : Scoreboard bench for pipe_generator plus a fast-speed instance
//            used to reach score saturation.
// Revision : 1.0
// ============================================================================
module tb_pipe_generator;

    localparam int         SW   = 640;
    localparam int         BX   = 100;
    localparam int         GY   = 100;
    localparam logic [7:0] SEED = 8'hA5;

    logic game_clk = 1'b0;
    always #5 game_clk = ~game_clk;

    logic        reset = 1'b1, restart = 1'b0, enable = 1'b0;
    logic [10:0] p1x, p1y, p2x, p2y;
    logic        sp;
    logic [11:0] sb;

    logic        f_reset = 1'b1, f_restart = 1'b0, f_enable = 1'b0;
    logic [10:0] f_p1x, f_p1y, f_p2x, f_p2y;
    logic        f_sp;
    logic [11:0] f_sb;

    pipe_generator dut (
        .game_clk(game_clk), .reset(reset), .restart(restart), .enable(enable),
        .pipe1_x(p1x), .pipe1_y(p1y), .pipe2_x(p2x), .pipe2_y(p2y),
        .score_pulse(sp), .score_bcd(sb)
    );

    pipe_generator #(.SPEED(8)) dut_fast (
        .game_clk(game_clk), .reset(f_reset), .restart(f_restart), .enable(f_enable),
        .pipe1_x(f_p1x), .pipe1_y(f_p1y), .pipe2_x(f_p2x), .pipe2_y(f_p2y),
        .score_pulse(f_sp), .score_bcd(f_sb)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [10:0] x1;
        logic [10:0] y1;
        logic [10:0] x2;
        logic [10:0] y2;
        logic        pulse;
        logic [11:0] score;
    } snap_t;

    snap_t exp_q[$];

    function automatic logic [11:0] to_bcd(input int s);
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge game_clk);
    endtask

    // Reference model for the default instance (SPEED = 1).
    int         m_st, mx1, my1, mx2, my2, m_score;
    logic [7:0] m_lfsr;
    bit         m_pulse;

    always @(posedge game_clk) begin : model
        logic [7:0] nl;
        bit         hit;
        snap_t      s;
        nl = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        if (reset) begin
            m_st = 0; m_lfsr = SEED; m_score = 0; m_pulse = 0;
            mx1 = 319; my1 = 250; mx2 = 639; my2 = 200;
        end else begin
            m_pulse = 0;
            if (restart) begin
                m_st = 0; m_score = 0;
                mx1 = 319; my1 = 250; mx2 = 639; my2 = 200;
            end else begin
                hit = 0;
                if (enable && m_st != 2) begin
                    if (mx1 == 0) begin
                        mx1 = SW - 1; my1 = GY + int'(m_lfsr);
                    end else begin
                        if (mx1 == BX) hit = 1;
                        mx1 = mx1 - 1;
                    end
                    if (mx2 == 0) begin
                        mx2 = SW - 1; my2 = GY + int'({m_lfsr[3:0], m_lfsr[7:4]});
                    end else begin
                        if (mx2 == BX) hit = 1;
                        mx2 = mx2 - 1;
                    end
                end
                if (hit) begin
                    m_pulse = 1;
                    if (m_score < 999) m_score = m_score + 1;
                end
                if (m_st == 0 && enable) m_st = 1;
                else if (m_st == 1 && !enable) m_st = 2;
            end
            m_lfsr = nl;
        end
        s.x1 = 11'(mx1); s.y1 = 11'(my1); s.x2 = 11'(mx2); s.y2 = 11'(my2);
        s.pulse = m_pulse; s.score = to_bcd(m_score);
        exp_q.push_back(s);
    end

    always @(negedge game_clk) begin : monitor
        snap_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({p1x, p1y, p2x, p2y, sp, sb} !== e) begin
                n_errors++;
                $display("FAIL scoreboard t=%0t got x1=%0d y1=%0d x2=%0d y2=%0d p=%0b s=%h exp x1=%0d y1=%0d x2=%0d y2=%0d p=%0b s=%h",
                         $time, p1x, p1y, p2x, p2y, sp, sb,
                         e.x1, e.y1, e.x2, e.y2, e.pulse, e.score);
            end
        end
    end

    // Fast instance: score tracking, saturation and spawn-height sanity.
    int          f_cnt = 0, f_late = 0;
    logic [10:0] f_prev1 = 11'd319, f_prev2 = 11'd639;
    bit          f_done = 0;

    always @(negedge game_clk) begin : fast_mon
        if (f_enable) begin
            if (f_sp) begin
                f_cnt++;
                if (f_cnt > 999) f_late++;
                chk("fast_score", int'(f_sb), int'(to_bcd(f_cnt > 999 ? 999 : f_cnt)));
            end
            if (f_prev1 < 11'd8 && f_p1x == 11'(SW - 1))
                chk("fast_spawn_y1", int'(f_p1y > 11'd100 && f_p1y <= 11'd355), 1);
            if (f_prev2 < 11'd8 && f_p2x == 11'(SW - 1))
                chk("fast_spawn_y2", int'(f_p2y > 11'd100 && f_p2y <= 11'd355), 1);
            f_prev1 = f_p1x;
            f_prev2 = f_p2x;
        end
    end

    initial begin : fast_stim
        ticks(3);
        f_reset = 1'b0;
        f_enable = 1'b1;
        ticks(41000);
        chk("fast_saturated", int'(f_sb), 12'h999);
        chk("fast_pulses_seen", int'(f_cnt >= 1000), 1);
        chk("fast_late_pulses", int'(f_late > 0), 1);
        f_done = 1;
    end

    initial begin : watchdog
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        ticks(3);
        chk("rst_x1", p1x, 319); chk("rst_x2", p2x, 639);
        chk("rst_y1", p1y, 250); chk("rst_y2", p2y, 200);
        chk("rst_score", sb, 0); chk("rst_pulse", sp, 0);

        reset = 1'b0; enable = 1'b1;
        ticks(10);
        chk("t10_x1", p1x, 309); chk("t10_x2", p2x, 629);
        chk("t10_y1", p1y, 250); chk("t10_y2", p2y, 200);
        ticks(209);
        chk("t219_x1", p1x, 100); chk("t219_pulse", sp, 0);
        ticks(1);
        chk("t220_x1", p1x, 99); chk("t220_pulse", sp, 1); chk("t220_score", sb, 12'h001);
        ticks(1);
        chk("t221_pulse", sp, 0); chk("t221_score", sb, 12'h001);
        ticks(98);
        chk("t319_x1", p1x, 0);
        ticks(1);
        chk("t320_x1_wrap", p1x, 639); chk("t320_x2", p2x, 319);
        ticks(220);
        chk("t540_x2", p2x, 99); chk("t540_pulse", sp, 1); chk("t540_score", sb, 12'h002);
        ticks(100);
        chk("t640_x2_wrap", p2x, 639); chk("t640_x1", p1x, 319);

        reset = 1'b1;
        ticks(1);
        chk("midrst_x1", p1x, 319); chk("midrst_x2", p2x, 639);
        chk("midrst_y2", p2y, 200); chk("midrst_score", sb, 0);
        reset = 1'b0;

        ticks(50);
        chk("t50_x1", p1x, 269); chk("t50_x2", p2x, 589);
        enable = 1'b0;
        ticks(1);
        chk("halt_x1", p1x, 269); chk("halt_x2", p2x, 589);
        enable = 1'b1;
        ticks(5);
        chk("halt_en_x1", p1x, 269); chk("halt_en_x2", p2x, 589);
        restart = 1'b1;
        ticks(1);
        chk("restart_x1", p1x, 319); chk("restart_x2", p2x, 639);
        chk("restart_y1", p1y, 250); chk("restart_y2", p2y, 200);
        chk("restart_score", sb, 0); chk("restart_pulse", sp, 0);
        restart = 1'b0;
        ticks(1);
        chk("idle_move_x1", p1x, 318);

        ticks(318);
        chk("pre_wrap_x1", p1x, 0);
        restart = 1'b1;
        ticks(1);
        chk("restart_wrap_x1", p1x, 319); chk("restart_wrap_y1", p1y, 250);
        restart = 1'b0;

        ticks(319);
        chk("hold_pre_x1", p1x, 0);
        enable = 1'b0;
        ticks(3);
        chk("hold_at_zero_x1", p1x, 0); chk("hold_at_zero_x2", p2x, 320);

        restart = 1'b1;
        ticks(1);
        restart = 1'b0; enable = 1'b1;
        ticks(700);
        chk("t700_score", sb, 12'h002);
        chk("t700_x2", p2x, 579);

        wait (f_done);
        ticks(1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
